host_rx_byte_packer: RTL and testbench

//  Downstream of the host-rx mapped-packet filter. Packs its 9-bit byte stream (bit8 marks the head and tail byte)

---
 rtl/host_rx_byte_packer_pkg.sv | 22 ++
 rtl/host_rx_byte_packer_sat_counter16.sv | 21 ++
 rtl/host_rx_byte_packer.sv | 189 ++++++++++++++++++
 tb/tb_host_rx_byte_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_rx_byte_packer_pkg.sv
// Shared host-rx definitions: field widths, packer FSM states, descriptor layout.
package host_rx_byte_packer_pkg;

    localparam int unsigned CTRL_W = 19;
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned DESC_W = CTRL_W + LEN_W;

    localparam int unsigned DESC_LEN_LSB  = 0;
    localparam int unsigned DESC_CTRL_LSB = LEN_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPack = 2'd1,
        StDisc = 2'd2
    } pack_state_e;

    // Lane 0 is the most significant byte of the word.
    function automatic logic [5:0] lane_lsb(input logic [2:0] lane);
        return {3'd7 - lane, 3'b000};
    endfunction

endpackage

// File: rtl/host_rx_byte_packer_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    output logic [15:0] ov_cnt
);

    logic [15:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_inc && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign ov_cnt = cnt_q;

endmodule

// File: rtl/host_rx_byte_packer.sv
// Packs the filtered host-rx byte stream into big-endian 64-bit buffer words and emits one
// descriptor per packet; drops packets at head when the buffer is nearly full, aborts oversize ones.
module host_rx_byte_packer
    import host_rx_byte_packer_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1522
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [8:0]        iv_data,
    input  logic              i_data_wr,
    input  logic [CTRL_W-1:0] iv_ctrl_data,
    input  logic              i_buf_afull,
    output logic [63:0]       ov_word_data,
    output logic [3:0]        ov_word_bytes,
    output logic              o_word_head,
    output logic              o_word_tail,
    output logic              o_word_abort,
    output logic              o_word_wr,
    output logic [DESC_W-1:0] ov_desc,
    output logic              o_desc_wr,
    output logic [15:0]       ov_drop_cnt,
    output logic [1:0]        ov_state
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    pack_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d, len_n;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              first_q, first_d;
    logic [63:0]       lanes_q, lanes_d, lanes_in;

    logic [63:0]       word_q, word_d;
    logic [3:0]        bytes_q, bytes_d;
    logic              head_q, head_d, tail_q, tail_d, abort_q, abort_d, wr_q, wr_d;
    logic [DESC_W-1:0] desc_q, desc_d;
    logic              desc_wr_q, desc_wr_d;
    logic              drop_inc;

    logic flag;
    assign flag = iv_data[8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ctrl_d    = ctrl_q;
        first_d   = first_q;
        lanes_d   = lanes_q;
        word_d    = '0;
        bytes_d   = '0;
        head_d    = 1'b0;
        tail_d    = 1'b0;
        abort_d   = 1'b0;
        wr_d      = 1'b0;
        desc_d    = '0;
        desc_wr_d = 1'b0;
        drop_inc  = 1'b0;

        len_n = len_q + LEN_W'(1);
        lanes_in = lanes_q;
        lanes_in[lane_lsb(cnt_q) +: 8] = iv_data[7:0];

        case (state_q)
            StIdle: begin
                if (i_data_wr && flag) begin
                    if (i_buf_afull) begin
                        drop_inc = 1'b1;
                        state_d  = StDisc;
                    end else begin
                        ctrl_d  = iv_ctrl_data;
                        lanes_d = {iv_data[7:0], 56'd0};
                        cnt_d   = 3'd1;
                        len_d   = LEN_W'(1);
                        first_d = 1'b1;
                        state_d = StPack;
                    end
                end
            end
            StPack: begin
                if (i_data_wr) begin
                    if (flag) begin
                        word_d    = lanes_in;
                        bytes_d   = {1'b0, cnt_q} + 4'd1;
                        head_d    = first_q;
                        tail_d    = 1'b1;
                        wr_d      = 1'b1;
                        desc_d    = {ctrl_q, len_n};
                        desc_wr_d = 1'b1;
                        lanes_d   = '0;
                        cnt_d     = '0;
                        len_d     = '0;
                        first_d   = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        len_d = len_n;
                        if (len_n > MaxLen) begin
                            // Oversize: flush what we have as an aborted tail so the buffer rolls back.
                            word_d   = lanes_in;
                            bytes_d  = {1'b0, cnt_q} + 4'd1;
                            head_d   = first_q;
                            tail_d   = 1'b1;
                            abort_d  = 1'b1;
                            wr_d     = 1'b1;
                            drop_inc = 1'b1;
                            lanes_d  = '0;
                            cnt_d    = '0;
                            first_d  = 1'b0;
                            state_d  = StDisc;
                        end else if (cnt_q == 3'd7) begin
                            word_d  = lanes_in;
                            bytes_d = 4'd8;
                            head_d  = first_q;
                            wr_d    = 1'b1;
                            first_d = 1'b0;
                            lanes_d = '0;
                            cnt_d   = '0;
                        end else begin
                            lanes_d = lanes_in;
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                end
            end
            StDisc: begin
                if (i_data_wr && flag) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            ctrl_q    <= '0;
            first_q   <= 1'b0;
            lanes_q   <= '0;
            word_q    <= '0;
            bytes_q   <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            abort_q   <= 1'b0;
            wr_q      <= 1'b0;
            desc_q    <= '0;
            desc_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            ctrl_q    <= ctrl_d;
            first_q   <= first_d;
            lanes_q   <= lanes_d;
            word_q    <= word_d;
            bytes_q   <= bytes_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            abort_q   <= abort_d;
            wr_q      <= wr_d;
            desc_q    <= desc_d;
            desc_wr_q <= desc_wr_d;
        end
    end

    sat_counter16 u_drop_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (drop_inc),
        .ov_cnt  (ov_drop_cnt)
    );

    assign ov_word_data  = word_q;
    assign ov_word_bytes = bytes_q;
    assign o_word_head   = head_q;
    assign o_word_tail   = tail_q;
    assign o_word_abort  = abort_q;
    assign o_word_wr     = wr_q;
    assign ov_desc       = desc_q;
    assign o_desc_wr     = desc_wr_q;
    assign ov_state      = state_q;

endmodule

// File: tb/tb_host_rx_byte_packer.sv
// Bench for host_rx_byte_packer: packet table driven through a byte-level reference model whose
// expected words/descriptors are queued and checked as the DUT emits them.
module tb_host_rx_byte_packer;
    import host_rx_byte_packer_pkg::*;

    localparam int MAX_LEN = 1522;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [8:0]        data = '0;
    logic              data_wr = 1'b0;
    logic [CTRL_W-1:0] ctrl = '0;
    logic              afull = 1'b0;
    logic [63:0]       word_data;
    logic [3:0]        word_bytes;
    logic              word_head, word_tail, word_abort, word_wr;
    logic [DESC_W-1:0] desc;
    logic              desc_wr;
    logic [15:0]       drop_cnt;
    logic [1:0]        state;

    host_rx_byte_packer #(.MAX_LEN(MAX_LEN)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .iv_data       (data),
        .i_data_wr     (data_wr),
        .iv_ctrl_data  (ctrl),
        .i_buf_afull   (afull),
        .ov_word_data  (word_data),
        .ov_word_bytes (word_bytes),
        .o_word_head   (word_head),
        .o_word_tail   (word_tail),
        .o_word_abort  (word_abort),
        .o_word_wr     (word_wr),
        .ov_desc       (desc),
        .o_desc_wr     (desc_wr),
        .ov_drop_cnt   (drop_cnt),
        .ov_state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  bytes;
        logic        head;
        logic        tail;
        logic        abort;
    } word_t;

    typedef struct {
        int          len;
        logic [18:0] ctrl;
        bit          afull;
        bit          gaps;
        int          exp_words;
        int          exp_descs;
        int          exp_drop;
    } vec_t;

    word_t       exp_words[$];
    logic [29:0] exp_descs[$];
    int checks = 0;
    int errors = 0;
    int words_seen = 0;
    int descs_seen = 0;
    int exp_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input int pkt, input int i);
        int v;
        v = i * 13 + pkt * 29 + 1;
        return v[7:0];
    endfunction

    // Reference model: walks the bytes the bench is about to send (only the first 'stop').
    task automatic model_pkt(input int pkt, input int len, input logic [18:0] c, input bit af,
                             input int stop);
        word_t w;
        logic [63:0] cur;
        int n;
        bit first;
        if (af) begin
            exp_drop++;
            return;
        end
        cur = '0;
        n = 0;
        first = 1'b1;
        for (int i = 0; i < stop; i++) begin
            cur[63 - 8 * n -: 8] = byte_of(pkt, i);
            n++;
            if (i == len - 1) begin
                w = '{cur, 4'(n), first, 1'b1, 1'b0};
                exp_words.push_back(w);
                exp_descs.push_back({c, 11'(len)});
                return;
            end
            if (i + 1 > MAX_LEN) begin
                w = '{cur, 4'(n), first, 1'b1, 1'b1};
                exp_words.push_back(w);
                exp_drop++;
                return;
            end
            if (n == 8) begin
                w = '{cur, 4'd8, first, 1'b0, 1'b0};
                exp_words.push_back(w);
                first = 1'b0;
                cur = '0;
                n = 0;
            end
        end
    endtask

    task automatic send_pkt(input int pkt, input int len, input logic [18:0] c, input bit af,
                            input bit gaps, input int stop);
        model_pkt(pkt, len, c, af, stop);
        for (int i = 0; i < stop; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                data_wr = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            data    = {(i == 0 || i == len - 1), byte_of(pkt, i)};
            data_wr = 1'b1;
            ctrl    = c;
            afull   = af;
            tick();
        end
        data_wr = 1'b0;
        afull   = 1'b0;
    endtask

    // Scoreboard side: compare every emitted word/descriptor against the queue head.
    always @(negedge clk) begin
        word_t w;
        logic [29:0] d;
        if (rst_n) begin
            if (word_wr) begin
                words_seen++;
                if (exp_words.size() == 0) begin
                    chk("unexpected_word", 64'(word_wr), 64'd0);
                end else begin
                    w = exp_words.pop_front();
                    chk("word_data", word_data, w.data);
                    chk("word_flags", 64'({word_bytes, word_head, word_tail, word_abort}),
                        64'({w.bytes, w.head, w.tail, w.abort}));
                end
            end
            if (desc_wr) begin
                descs_seen++;
                if (exp_descs.size() == 0) begin
                    chk("unexpected_desc", 64'(desc_wr), 64'd0);
                end else begin
                    d = exp_descs.pop_front();
                    chk("desc", 64'(desc), 64'(d));
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_word_data"}, word_data, 64'd0);
        chk({tag, "_word_ctl"}, 64'({word_bytes, word_head, word_tail, word_abort, word_wr}), 64'd0);
        chk({tag, "_desc"}, 64'(desc), 64'd0);
        chk({tag, "_desc_wr"}, 64'(desc_wr), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        chk({tag, "_state"}, 64'(state), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int ws0, ds0;
        vecs[0] = '{64,   19'h5A5A5, 1'b0, 1'b0, 8,   1, 0};
        vecs[1] = '{61,   19'h12345, 1'b0, 1'b0, 8,   1, 0};
        vecs[2] = '{100,  19'h7FFFF, 1'b1, 1'b0, 0,   0, 1};
        vecs[3] = '{20,   19'h00001, 1'b0, 1'b1, 3,   1, 1};
        vecs[4] = '{1600, 19'h2AAAA, 1'b0, 1'b0, 191, 0, 2};
        vecs[5] = '{2,    19'h3C3C3, 1'b0, 1'b0, 1,   1, 2};
        vecs[6] = '{8,    19'h0F0F0, 1'b0, 1'b1, 1,   1, 2};
        vecs[7] = '{1522, 19'h11111, 1'b0, 1'b0, 191, 1, 2};

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            ws0 = words_seen;
            ds0 = descs_seen;
            send_pkt(i, vecs[i].len, vecs[i].ctrl, vecs[i].afull, vecs[i].gaps, vecs[i].len);
            repeat (4) tick();
            chk($sformatf("v%0d_words", i), 64'(words_seen - ws0), 64'(vecs[i].exp_words));
            chk($sformatf("v%0d_descs", i), 64'(descs_seen - ds0), 64'(vecs[i].exp_descs));
            chk($sformatf("v%0d_drop", i), 64'(drop_cnt), 64'(vecs[i].exp_drop));
            chk($sformatf("v%0d_model_drop", i), 64'(drop_cnt), 64'(exp_drop));
            chk($sformatf("v%0d_pending", i), 64'(exp_words.size() + exp_descs.size()), 64'd0);
        end

        // Back-to-back 9-byte packets, zero gap between them, random gaps inside.
        ws0 = words_seen;
        ds0 = descs_seen;
        send_pkt(20, 9, 19'h4B4B4, 1'b0, 1'b1, 9);
        send_pkt(21, 9, 19'h0ABCD, 1'b0, 1'b1, 9);
        repeat (4) tick();
        chk("b2b_words", 64'(words_seen - ws0), 64'd4);
        chk("b2b_descs", 64'(descs_seen - ds0), 64'd2);
        chk("b2b_pending", 64'(exp_words.size() + exp_descs.size()), 64'd0);

        // Dropped head parks the FSM in discard until the tail.
        send_pkt(22, 30, 19'h00F00, 1'b1, 1'b0, 10);
        chk("disc_state", 64'(state), 64'd2);
        send_pkt(22, 30, 19'h00F00, 1'b0, 1'b0, 0);
        data = {1'b1, 8'h55};
        data_wr = 1'b1;
        tick();
        data_wr = 1'b0;
        tick();
        chk("disc_exit_state", 64'(state), 64'd0);
        chk("disc_drop", 64'(drop_cnt), 64'(exp_drop));

        // Reset in the middle of a packet: partial word and descriptor are lost.
        send_pkt(23, 40, 19'h13579, 1'b0, 1'b0, 20);
        @(negedge clk);
        chk("pre_reset_pending", 64'(exp_words.size()), 64'd0);
        rst_n = 1'b0;
        exp_drop = 0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ws0 = words_seen;
        ds0 = descs_seen;
        send_pkt(24, 9, 19'h2468A, 1'b0, 1'b0, 9);
        repeat (4) tick();
        chk("post_reset_words", 64'(words_seen - ws0), 64'd2);
        chk("post_reset_descs", 64'(descs_seen - ds0), 64'd1);
        chk("post_reset_pending", 64'(exp_words.size() + exp_descs.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
